// File: rtl/fp_add_issue_ctrl.sv
// Issue/capture controller for the pipelined single-precision adder.
// Optional FP_ADD_ISSUE_SPECIAL_EN adds an Inf/NaN sideband flag (out_special).
module fp_add_issue_ctrl #(
    parameter int LAT        = 1,
    parameter int FIFO_DEPTH = 2
) (
    input  logic        aclk,
    input  logic        arst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    input  logic [2:0]  in_rm,
    output logic        a_sign,
    output logic [7:0]  a_exp,
    output logic [22:0] a_man,
    output logic        b_sign,
    output logic [7:0]  b_exp,
    output logic [22:0] b_man,
    output logic [2:0]  rm,
    output logic        astall,
    input  logic [31:0] x,
    output logic        out_valid,
    input  logic        out_ready,
`ifdef FP_ADD_ISSUE_SPECIAL_EN
    output logic        out_special,
`endif
    output logic [31:0] out_x
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic           v0;
    logic [LAT:1]   vld;
    logic [CW-1:0]  count;
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;
    logic [31:0]    mem [FIFO_DEPTH];
    logic           fifo_full;
    logic           wr_en;
    logic           rd_en;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // full comes from the count register, so out_ready never reaches astall
    assign fifo_full = (count == CW'(FIFO_DEPTH));
    assign astall    = vld[LAT] & fifo_full;
    assign in_ready  = ~astall;
    assign wr_en     = vld[LAT] & ~fifo_full;
    assign out_valid = (count != '0);
    assign rd_en     = out_valid & out_ready;
    assign out_x     = mem[rd_ptr];

    always_ff @(posedge aclk or negedge arst_n) begin
        if (!arst_n) begin
            v0     <= 1'b0;
            a_sign <= 1'b0;
            a_exp  <= '0;
            a_man  <= '0;
            b_sign <= 1'b0;
            b_exp  <= '0;
            b_man  <= '0;
            rm     <= '0;
        end else if (!astall) begin
            v0 <= in_valid;
            if (in_valid) begin
                a_sign <= in_a[31];
                a_exp  <= in_a[30:23];
                a_man  <= in_a[22:0];
                b_sign <= in_b[31];
                b_exp  <= in_b[30:23];
                b_man  <= in_b[22:0];
                rm     <= in_rm;
            end
        end
    end

    always_ff @(posedge aclk or negedge arst_n) begin
        if (!arst_n) begin
            vld <= '0;
        end else if (!astall) begin
            vld[1] <= v0;
            for (int k = 2; k <= LAT; k++) vld[k] <= vld[k-1];
        end
    end

    always_ff @(posedge aclk or negedge arst_n) begin
        if (!arst_n) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) wr_ptr <= ptr_next(wr_ptr);
            if (rd_en) rd_ptr <= ptr_next(rd_ptr);
            count <= count + CW'(wr_en) - CW'(rd_en);
        end
    end

    always_ff @(posedge aclk) begin
        if (wr_en) mem[wr_ptr] <= x;
    end

`ifdef FP_ADD_ISSUE_SPECIAL_EN
    logic         sp0;
    logic [LAT:1] sp;
    logic         smem [FIFO_DEPTH];

    // sideband mirrors the operand stage and vld exactly
    always_ff @(posedge aclk or negedge arst_n) begin
        if (!arst_n) begin
            sp0 <= 1'b0;
            sp  <= '0;
        end else if (!astall) begin
            if (in_valid)
                sp0 <= (in_a[30:23] == 8'hFF) | (in_b[30:23] == 8'hFF);
            sp[1] <= sp0;
            for (int k = 2; k <= LAT; k++) sp[k] <= sp[k-1];
        end
    end

    always_ff @(posedge aclk) begin
        if (wr_en) smem[wr_ptr] <= sp[LAT];
    end

    assign out_special = smem[rd_ptr];
`endif

endmodule

// File: tb/tb_fp_add_issue_ctrl.sv
// Directed bench for fp_add_issue_ctrl with a stallable adder model.
// Define FP_ADD_ISSUE_SPECIAL_EN to also check out_special.
module tb_fp_add_issue_ctrl;

    localparam int LAT = 1;
    localparam int FD  = 2;

    logic        aclk = 1'b0;
    logic        arst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_a = '0;
    logic [31:0] in_b = '0;
    logic [2:0]  in_rm = '0;
    logic        a_sign, b_sign;
    logic [7:0]  a_exp, b_exp;
    logic [22:0] a_man, b_man;
    logic [2:0]  rm;
    logic        astall;
    logic [31:0] x;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_x;
`ifdef FP_ADD_ISSUE_SPECIAL_EN
    logic        out_special;
`endif

    fp_add_issue_ctrl #(.LAT(LAT), .FIFO_DEPTH(FD)) dut (
        .aclk(aclk), .arst_n(arst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_rm(in_rm),
        .a_sign(a_sign), .a_exp(a_exp), .a_man(a_man),
        .b_sign(b_sign), .b_exp(b_exp), .b_man(b_man),
        .rm(rm), .astall(astall), .x(x),
        .out_valid(out_valid), .out_ready(out_ready),
`ifdef FP_ADD_ISSUE_SPECIAL_EN
        .out_special(out_special),
`endif
        .out_x(out_x)
    );

    always #5 aclk = ~aclk;

    // crude positive-normal float add, truncating
    function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
        logic [7:0]  ea, eb, e, t;
        logic [24:0] ma, mb, s, u;
        int d;
        ea = a[30:23]; eb = b[30:23];
        ma = {2'b01, a[22:0]}; mb = {2'b01, b[22:0]};
        if (eb > ea) begin
            t = ea; ea = eb; eb = t;
            u = ma; ma = mb; mb = u;
        end
        d = int'(ea) - int'(eb);
        e = ea;
        mb = (d > 24) ? '0 : (mb >> d);
        s = ma + mb;
        if (s[24]) begin
            s = s >> 1;
            e = e + 8'd1;
        end
        return {1'b0, e, s[22:0]};
    endfunction

    logic [31:0] pipe [LAT:1];
    always @(posedge aclk or negedge arst_n) begin
        if (!arst_n) begin
            for (int k = 1; k <= LAT; k++) pipe[k] <= '0;
        end else if (!astall) begin
            pipe[1] <= fadd({a_sign, a_exp, a_man}, {b_sign, b_exp, b_man});
            for (int k = 2; k <= LAT; k++) pipe[k] <= pipe[k-1];
        end
    end
    assign x = pipe[LAT];

    int passed = 0;
    int total  = 0;
    int idx    = 0;
    int nops   = 0;
    int got    = 0;
    logic [31:0] opa [32];
    logic [31:0] opb [32];
    logic [31:0] expq [$];
    logic        sq [$];
    logic [31:0] e;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic issue_step();
        if (idx < nops) begin
            in_valid = 1'b1;
            in_a = opa[idx];
            in_b = opb[idx];
            if (in_ready) begin
                expq.push_back(fadd(opa[idx], opb[idx]));
                sq.push_back((opa[idx][30:23] == 8'hFF) | (opb[idx][30:23] == 8'hFF));
                idx++;
            end
        end else begin
            in_valid = 1'b0;
        end
    endtask

    task automatic fill(input int cycles);
        out_ready = 1'b0;
        repeat (cycles) begin
            issue_step();
            tick();
        end
    endtask

    task automatic check_head(input string tag);
        if (expq.size() == 0) begin
            chk({tag, "_extra"}, 32'(out_valid), 32'd0);
        end else begin
            e = expq.pop_front();
            chk(tag, out_x, e);
`ifdef FP_ADD_ISSUE_SPECIAL_EN
            chk({tag, "_special"}, 32'(out_special), 32'(sq[0]));
`endif
            void'(sq.pop_front());
        end
    endtask

    task automatic drain_all(input string tag, input int n, input int budget);
        out_ready = 1'b1;
        got = 0;
        repeat (budget) begin
            issue_step();
            if (out_valid) begin
                check_head(tag);
                got++;
            end
            tick();
        end
        in_valid = 1'b0;
        chk({tag, "_count"}, 32'(got), 32'(n));
    endtask

    initial begin
        // reset state
        #2;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_astall", 32'(astall), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_a_exp", 32'(a_exp), 32'd0);
        chk("rst_rm", 32'(rm), 32'd0);
        tick();
        tick();
        arst_n = 1'b1;
        tick();

        // single op: accept in cycle 0, result in cycle 3
        out_ready = 1'b1;
        in_valid = 1'b1;
        in_a = 32'h3F800000;
        in_b = 32'h40000000;
        in_rm = 3'd5;
        chk("one_in_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        chk("one_a_exp", 32'(a_exp), 32'h7F);
        chk("one_b_exp", 32'(b_exp), 32'h80);
        chk("one_rm", 32'(rm), 32'd5);
        chk("one_c1_valid", 32'(out_valid), 32'd0);
        tick();
        chk("one_c2_valid", 32'(out_valid), 32'd0);
        tick();
        chk("one_c3_valid", 32'(out_valid), 32'd1);
        chk("one_c3_x", out_x, 32'h40400000);
        tick();
        chk("one_c4_valid", 32'(out_valid), 32'd0);

        // 20 back-to-back ops, one result per cycle
        for (int i = 0; i < 20; i++) begin
            opa[i] = 32'h3F800000 + (i << 16);
            opb[i] = 32'h40000000 + (i << 12);
        end
        nops = 20;
        idx = 0;
        for (int j = 0; j < 23; j++) begin
            issue_step();
            chk("b2b_astall", 32'(astall), 32'd0);
            if (j >= 3) begin
                chk("b2b_valid", 32'(out_valid), 32'd1);
                check_head("b2b_x");
            end
            tick();
        end
        in_valid = 1'b0;
        chk("b2b_issued", 32'(idx), 32'd20);
        chk("b2b_empty", 32'(out_valid), 32'd0);

        // backpressure: 5 ops into a 2-entry FIFO with out_ready low
        for (int i = 0; i < 5; i++) begin
            opa[i] = 32'h40400000 + (i << 18);
            opb[i] = 32'h3F000000 + (i << 10);
        end
        nops = 5;
        idx = 0;
        fill(10);
        chk("bp_astall", 32'(astall), 32'd1);
        chk("bp_in_ready", 32'(in_ready), 32'd0);
        chk("bp_accepted", 32'(idx), 32'd4);
        chk("bp_valid", 32'(out_valid), 32'd1);
        chk("bp_head", out_x, expq[0]);
        drain_all("bp_drain", 5, 20);
        chk("bp_all_issued", 32'(idx), 32'd5);

        // full FIFO with a result waiting, out_ready pulsed once
        for (int i = 0; i < 3; i++) begin
            opa[i] = 32'h41000000 + (i << 20);
            opb[i] = 32'h3F800000;
        end
        nops = 3;
        idx = 0;
        out_ready = 1'b0;
        for (int t = 0; t < 10 && !astall; t++) begin
            issue_step();
            tick();
        end
        in_valid = 1'b0;
        chk("col_stall", 32'(astall), 32'd1);
        out_ready = 1'b1;
        check_head("col_rd0");
        tick();
        out_ready = 1'b0;
        chk("col_after_rd_stall", 32'(astall), 32'd0);
        chk("col_after_rd_ready", 32'(in_ready), 32'd1);
        chk("col_after_rd_head", out_x, expq[0]);
        tick();
        chk("col_after_wr_stall", 32'(astall), 32'd0);
        chk("col_after_wr_valid", 32'(out_valid), 32'd1);
        drain_all("col_drain", 2, 8);

        // reset with work in flight and buffered
        for (int i = 0; i < 5; i++) begin
            opa[i] = 32'h3FC00000 + (i << 16);
            opb[i] = 32'h40800000;
        end
        nops = 5;
        idx = 0;
        fill(5);
        chk("rr_pre_stall", 32'(astall), 32'd1);
        #2;
        arst_n = 1'b0;
        #1;
        chk("rr_out_valid", 32'(out_valid), 32'd0);
        chk("rr_astall", 32'(astall), 32'd0);
        chk("rr_in_ready", 32'(in_ready), 32'd1);
        expq.delete();
        sq.delete();
        in_valid = 1'b0;
        tick();
        tick();
        arst_n = 1'b1;
        tick();
        opa[0] = 32'h40A00000;
        opb[0] = 32'h40400000;
        nops = 1;
        idx = 0;
        drain_all("rr_new", 1, 10);

`ifdef FP_ADD_ISSUE_SPECIAL_EN
        opa[0] = 32'h7FC00000; opb[0] = 32'h3F800000;
        opa[1] = 32'h3F800000; opb[1] = 32'h40000000;
        nops = 2;
        idx = 0;
        drain_all("sp_basic", 2, 8);
        opa[2] = 32'h7FC00000; opb[2] = 32'h40000000;
        opa[3] = 32'h40400000; opb[3] = 32'h3F800000;
        nops = 4;
        idx = 0;
        fill(8);
        chk("sp_bp_stall", 32'(astall), 32'd1);
        drain_all("sp_bp", 4, 16);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
